// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART-to-bus debug bridge.
// Contents: FSM state enum, command bytes, default response bytes, word geometry.
package uart_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StReq,
    StAcc,
    StRdw,
    StRel,
    StTx
  } state_e;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'

  localparam logic [7:0] DEF_RSP_ACK = 8'h06;
  localparam logic [7:0] DEF_RSP_NAK = 8'h15;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Guard counters cover the strobe cycle plus the two cycles after it.
  localparam logic [1:0] GUARD_RELOAD = 2'd3;

endpackage

// File: rtl/byte_shift_reg.sv
// Four-byte LSB-first assembler/serialiser.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   load, load_val      parallel load of a full word (highest priority)
//   shift_in, in_byte   shift a byte in at the top; after four shifts the first byte is the LSB
//   shift_out           drop the LSB byte, zero-fill at the top
//   word                current contents; word[7:0] is the next byte to serialise
module byte_shift_reg
  import uart_bus_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [8*BYTES_PER_WORD-1:0] load_val,
  input  logic                        shift_in,
  input  logic [7:0]                  in_byte,
  input  logic                        shift_out,
  output logic [8*BYTES_PER_WORD-1:0] word
);

  localparam int unsigned W = 8 * BYTES_PER_WORD;

  logic [W-1:0] word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= load_val;
    end else if (shift_in) begin
      word_q <= {in_byte, word_q[W-1:8]};
    end else if (shift_out) begin
      word_q <= {8'h00, word_q[W-1:8]};
    end
  end

  assign word = word_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command-frame to 32-bit bus bridge (second bus initiator for debug/boot).
// Frames: 'W' a0..a3 d0..d3 -> ACK byte; 'R' a0..a3 -> four data bytes; all LSB-first.
// Ports:
//   clk, reset_i                         clock, synchronous active-high reset
//   rx_data_i, rx_valid_i, rx_rd_o       UART receive side (rx_rd_o pulses to consume)
//   tx_data_o, tx_wr_o, tx_busy_i        UART transmit side (tx_wr_o pulses to send)
//   bus_req_o, bus_gnt_i                 bus request/grant handshake
//   addr_o, we_o, wr_mask_o, data_out_o  bus access, non-zero only in ACC/RDW
//   data_in_i                            read data, valid the cycle after the address
//   active_o                             high whenever the FSM is not idle
module uart_bus_bridge
  import uart_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0]  RSP_ACK        = DEF_RSP_ACK,
  parameter logic [7:0]  RSP_NAK        = DEF_RSP_NAK
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_rd_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_wr_o,
  input  logic        tx_busy_i,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] addr_o,
  output logic        we_o,
  output logic [3:0]  wr_mask_o,
  output logic [31:0] data_out_o,
  input  logic [31:0] data_in_i,
  output logic        active_o
);

  localparam logic [31:0] TmoLast  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LastByte = 2'(BYTES_PER_WORD - 1);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic        is_write_q, is_write_d;
  logic        rx_rd_q, rx_rd_d;
  logic [1:0]  rx_guard_q, rx_guard_d;
  logic        tx_wr_q, tx_wr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [1:0]  tx_guard_q, tx_guard_d;
  logic [2:0]  tx_left_q, tx_left_d;

  logic        rx_take, tx_send;
  logic        addr_shift_in;
  logic        data_shift_in, data_shift_out, data_load;
  logic [31:0] data_load_val;
  logic [31:0] addr_word, data_word;

  // Address assembler.
  byte_shift_reg u_addr_sr (
    .clk       (clk),
    .reset     (reset_i),
    .load      (1'b0),
    .load_val  (32'h0),
    .shift_in  (addr_shift_in),
    .in_byte   (rx_data_i),
    .shift_out (1'b0),
    .word      (addr_word)
  );

  // Write data in, then reused as the response serialiser once the access is done.
  byte_shift_reg u_data_sr (
    .clk       (clk),
    .reset     (reset_i),
    .load      (data_load),
    .load_val  (data_load_val),
    .shift_in  (data_shift_in),
    .in_byte   (rx_data_i),
    .shift_out (data_shift_out),
    .word      (data_word)
  );

  // Bytes are only consumed while a frame is being parsed; later ones wait in the UART.
  assign rx_take = rx_valid_i && (rx_guard_q == 2'd0) &&
                   (state_q == StIdle || state_q == StAddr || state_q == StData);
  assign tx_send = (state_q == StTx) && (tx_left_q != 3'd0) && !tx_busy_i &&
                   (tx_guard_q == 2'd0);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= StIdle;
      byte_cnt_q <= 2'd0;
      tmo_q      <= 32'd0;
      is_write_q <= 1'b0;
      rx_rd_q    <= 1'b0;
      rx_guard_q <= 2'd0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_guard_q <= 2'd0;
      tx_left_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      is_write_q <= is_write_d;
      rx_rd_q    <= rx_rd_d;
      rx_guard_q <= rx_guard_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
      tx_guard_q <= tx_guard_d;
      tx_left_q  <= tx_left_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    tmo_d          = tmo_q;
    is_write_d     = is_write_q;
    rx_rd_d        = rx_take;
    rx_guard_d     = (rx_guard_q != 2'd0) ? rx_guard_q - 2'd1 : 2'd0;
    tx_wr_d        = tx_send;
    tx_data_d      = tx_data_q;
    tx_guard_d     = (tx_guard_q != 2'd0) ? tx_guard_q - 2'd1 : 2'd0;
    tx_left_d      = tx_left_q;
    addr_shift_in  = 1'b0;
    data_shift_in  = 1'b0;
    data_shift_out = 1'b0;
    data_load      = 1'b0;
    data_load_val  = 32'h0;
    bus_req_o      = 1'b0;
    addr_o         = 32'h0;
    we_o           = 1'b0;
    wr_mask_o      = 4'h0;
    data_out_o     = 32'h0;

    if (rx_take) rx_guard_d = GUARD_RELOAD;

    unique case (state_q)
      StIdle: begin
        tmo_d      = 32'd0;
        byte_cnt_d = 2'd0;
        if (rx_take) begin
          if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
            is_write_d = (rx_data_i == CMD_WRITE);
            state_d    = StAddr;
          end else begin
            data_load     = 1'b1;
            data_load_val = {24'h0, RSP_NAK};
            tx_left_d     = 3'd1;
            state_d       = StTx;
          end
        end
      end
      StAddr, StData: begin
        if (rx_take) begin
          addr_shift_in = (state_q == StAddr);
          data_shift_in = (state_q == StData);
          tmo_d         = 32'd0;
          byte_cnt_d    = byte_cnt_q + 2'd1;
          if (byte_cnt_q == LastByte) begin
            state_d = (state_q == StAddr && is_write_q) ? StData : StReq;
          end
        end else if (tmo_q == TmoLast) begin
          // Abandoned frame: drop it without any response.
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StReq: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) state_d = StAcc;
      end
      StAcc: begin
        bus_req_o = 1'b1;
        addr_o    = addr_word & ~32'h3;
        if (is_write_q) begin
          we_o          = 1'b1;
          wr_mask_o     = 4'hF;
          data_out_o    = data_word;
          data_load     = 1'b1;
          data_load_val = {24'h0, RSP_ACK};
          tx_left_d     = 3'd1;
          state_d       = StRel;
        end else begin
          state_d = StRdw;
        end
      end
      StRdw: begin
        bus_req_o     = 1'b1;
        addr_o        = addr_word & ~32'h3;
        data_load     = 1'b1;
        data_load_val = data_in_i;
        tx_left_d     = 3'(BYTES_PER_WORD);
        state_d       = StRel;
      end
      StRel: begin
        state_d = StTx;
      end
      StTx: begin
        if (tx_send) begin
          tx_data_d      = data_word[7:0];
          data_shift_out = 1'b1;
          tx_left_d      = tx_left_q - 3'd1;
          tx_guard_d     = GUARD_RELOAD;
        end else if (tx_left_q == 3'd0 && tx_guard_q == 2'd0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_rd_o   = rx_rd_q;
  assign tx_wr_o   = tx_wr_q;
  assign tx_data_o = tx_data_q;
  assign active_o  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: table of frames plus hand-written corner sequences.
module tb_uart_bus_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_rd;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        tx_busy_force = 1'b0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  wr_mask;
  logic [31:0] data_out;
  logic [31:0] data_in = 32'h0;
  logic        active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_bus_bridge #(
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .reset_i    (reset),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_rd_o    (rx_rd),
    .tx_data_o  (tx_data),
    .tx_wr_o    (tx_wr),
    .tx_busy_i  (tx_busy),
    .bus_req_o  (bus_req),
    .bus_gnt_i  (bus_gnt),
    .addr_o     (addr),
    .we_o       (we),
    .wr_mask_o  (wr_mask),
    .data_out_o (data_out),
    .data_in_i  (data_in),
    .active_o   (active)
  );

  // Bus target: synchronous-read memory and a grant that follows req after gnt_delay cycles.
  logic [31:0] mem [logic [31:0]];
  int          req_age = 0;
  int          gnt_delay = 3;
  logic        gnt_block = 1'b0;

  always @(posedge clk) begin
    data_in <= mem.exists(addr) ? mem[addr] : 32'h0;
    req_age <= bus_req ? req_age + 1 : 0;
    bus_gnt <= bus_req && !gnt_block && (req_age + 1 >= gnt_delay);
  end

  // UART transmitter: busy rises one cycle late after a strobe and stays high 5 cycles.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_wr) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = tx_busy_force || (busy_cnt >= 1 && busy_cnt <= 5);

  // Observers.
  logic [7:0]  tx_q[$];
  logic        tx_wr_prev = 1'b0;
  int          we_cnt = 0;
  int          req_cycles = 0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [3:0]  last_mask = 4'h0;

  always @(negedge clk) begin
    if (tx_wr) begin
      tx_q.push_back(tx_data);
      checks++;
      if (tx_wr_prev) begin
        errors++;
        $display("FAIL tx_wr_width: strobe high for 2+ cycles, required 1");
      end
    end
    tx_wr_prev = tx_wr;
    if (we) begin
      we_cnt++;
      last_wdata = data_out;
      last_mask  = wr_mask;
      mem[addr]  = data_out;
    end
    if (bus_req) req_cycles++;
    if (addr != 32'h0) last_addr = addr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Present a byte and hold valid one cycle past rx_rd, as a late-clearing UART does.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_rd && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_rd) begin
      check("rx_take_timeout", 32'(rx_rd), 32'h1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    check("rx_rd_width", 32'(rx_rd), 32'h0);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tx_idle(input int n_bytes);
    int n = 0;
    while ((tx_q.size() < n_bytes || active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("idle_timeout", 32'(active), 32'h0);
  endtask

  task automatic wait_req(input logic level);
    int n = 0;
    while (bus_req != level && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bus_req_level", 32'(bus_req), 32'(level));
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
    send_byte(cmd);
    if (cmd == 8'h57 || cmd == 8'h52)
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (cmd == 8'h57)
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_bus;
    logic [31:0] exp_addr;
    logic        exp_we;
    int          exp_n;
    logic [31:0] exp_tx;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int we0, req0;
    tx_q.delete();
    we0 = we_cnt;
    req0 = req_cycles;
    last_addr = 32'h0;
    send_frame(v.cmd, v.addr, v.wdata);
    wait_tx_idle(v.exp_n);
    check("tx_count", 32'(tx_q.size()), 32'(v.exp_n));
    for (int i = 0; i < v.exp_n && i < tx_q.size(); i++)
      check("tx_byte", 32'(tx_q[i]), 32'(v.exp_tx[8*i +: 8]));
    check("we_pulses", 32'(we_cnt - we0), 32'(v.exp_we));
    if (v.exp_bus) check("acc_addr", last_addr, v.exp_addr);
    else check("no_bus_req", 32'(req_cycles - req0), 32'h0);
    if (v.exp_we) begin
      check("wdata", last_wdata, v.wdata);
      check("wr_mask", 32'(last_mask), 32'hF);
    end
    check("active_end", 32'(active), 32'h0);
  endtask

  initial begin
    int we0, req0, n;
    logic stall_bad;

    vecs[0] = '{8'h57, 32'h1000_0000, 32'hDEAD_BEEF, 1'b1, 32'h1000_0000, 1'b1, 1, 32'h06};
    vecs[1] = '{8'h52, 32'h1000_0004, 32'h0, 1'b1, 32'h1000_0004, 1'b0, 4, 32'h1234_5678};
    vecs[2] = '{8'h52, 32'h1000_0007, 32'h0, 1'b1, 32'h1000_0004, 1'b0, 4, 32'h1234_5678};
    vecs[3] = '{8'h41, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 32'h15};
    vecs[4] = '{8'h57, 32'h0000_0102, 32'hA5A5_0F0F, 1'b1, 32'h0000_0100, 1'b1, 1, 32'h06};
    vecs[5] = '{8'h52, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 4, 32'hA5A5_0F0F};
    mem[32'h1000_0004] = 32'h1234_5678;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_active", 32'(active), 32'h0);
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_tx_wr", 32'(tx_wr), 32'h0);
    check("rst_rx_rd", 32'(rx_rd), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_addr", addr, 32'h0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Timeout: partial frame, then silence.
    tx_q.delete();
    we0 = we_cnt;
    req0 = req_cycles;
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (80) @(negedge clk);
    check("tmo_still_active", 32'(active), 32'h1);
    repeat (40) @(negedge clk);
    check("tmo_idle", 32'(active), 32'h0);
    check("tmo_no_req", 32'(req_cycles - req0), 32'h0);
    check("tmo_no_we", 32'(we_cnt - we0), 32'h0);
    check("tmo_no_tx", 32'(tx_q.size()), 32'h0);
    run_vec(vecs[1]);

    // Grant stall on a write.
    tx_q.delete();
    we0 = we_cnt;
    gnt_block = 1'b1;
    send_frame(8'h57, 32'h1000_0008, 32'hCAFE_F00D);
    wait_req(1'b1);
    stall_bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!bus_req || we) stall_bad = 1'b1;
      @(negedge clk);
    end
    check("stall_req_held", 32'(stall_bad), 32'h0);
    gnt_block = 1'b0;
    wait_tx_idle(1);
    check("stall_we_pulses", 32'(we_cnt - we0), 32'h1);
    check("stall_wdata", last_wdata, 32'hCAFE_F00D);
    check("stall_ack", tx_q.size() > 0 ? 32'(tx_q[0]) : 32'hFFFF_FFFF, 32'h06);

    // TX backpressure on a read response.
    tx_q.delete();
    tx_busy_force = 1'b1;
    send_frame(8'h52, 32'h1000_0008, 32'h0);
    wait_req(1'b1);
    wait_req(1'b0);
    repeat (40) @(negedge clk);
    check("busy_no_tx", 32'(tx_q.size()), 32'h0);
    check("busy_active", 32'(active), 32'h1);
    tx_busy_force = 1'b0;
    wait_tx_idle(4);
    check("busy_tx_count", 32'(tx_q.size()), 32'h4);
    n = tx_q.size();
    if (n == 4) check("busy_rdata", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'hCAFE_F00D);

    // Reset while the request is pending.
    tx_q.delete();
    we0 = we_cnt;
    gnt_block = 1'b1;
    send_frame(8'h57, 32'h1000_000C, 32'h1111_2222);
    wait_req(1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_req", 32'(bus_req), 32'h0);
    check("mid_rst_active", 32'(active), 32'h0);
    check("mid_rst_tx_data", 32'(tx_data), 32'h0);
    check("mid_rst_bus", {addr[31:4], we, wr_mask[2:0]} | data_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    gnt_block = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rst_no_we", 32'(we_cnt - we0), 32'h0);
    check("mid_rst_no_tx", 32'(tx_q.size()), 32'h0);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
